// File: rtl/icache_pkg.sv
// Shared widths and FSM encoding for the instruction-cache refill path.
package icache_pkg;

  localparam int TAG_BITS_WIDTH          = 8;
  localparam int SET_BITS_WIDTH          = 4;
  localparam int BLOCK_OFFSET_BITS_WIDTH = 4;
  localparam int WORD_WIDTH              = 20;
  localparam int NUM_WAYS                = 4;
  localparam int MEM_IF_DATA_WIDTH       = 128;
  localparam int WORDS_PER_BEAT          = 4;
  localparam int BEATS_PER_BLOCK         = 4;
  localparam int BEAT_BITS               = WORDS_PER_BEAT * WORD_WIDTH;
  localparam int STATUS_WIDTH            = 2 * NUM_WAYS;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_REQ     = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_WRITE   = 3'd3;
  localparam logic [2:0] ST_TAG     = 3'd4;
  localparam logic [2:0] ST_RESTART = 3'd5;

endpackage

// File: rtl/icache_victim_select.sv
// Victim way choice and the status-word update written once the refill lands.
module icache_victim_select
  import icache_pkg::*;
(
  input  logic [STATUS_WIDTH-1:0] status,
  output logic [NUM_WAYS-1:0]     victim,
  output logic [STATUS_WIDTH-1:0] new_status,
  output logic [STATUS_WIDTH-1:0] status_mask
);

  logic found;
  logic others_used;

  // Invalid way first, then unused way, then way 0; victim gets valid+used,
  // and when that leaves every way used the other used bits are cleared.
  always_comb begin
    victim      = '0;
    found       = 1'b0;
    others_used = 1'b1;
    new_status  = status;
    status_mask = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!found && !status[2*w+1]) begin
        victim[w] = 1'b1;
        found     = 1'b1;
      end
    end
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!found && !status[2*w]) begin
        victim[w] = 1'b1;
        found     = 1'b1;
      end
    end
    if (!found) victim[0] = 1'b1;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!victim[w] && !status[2*w]) others_used = 1'b0;
      if (victim[w]) begin
        new_status[2*w+:2]  = 2'b11;
        status_mask[2*w+:2] = 2'b11;
      end
    end
    if (others_used) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (!victim[w]) new_status[2*w] = 1'b0;
      end
      status_mask = '1;
    end
  end

endmodule

// File: rtl/icache_refill_controller.sv
// Instruction-cache miss handler: fetch 4 beats, write 16 words, update
// tag/status, then replay the missed address while holding the front pipe.
//
//  state   | meaning
//  IDLE    | ready for a miss
//  REQ     | memory request for current beat outstanding
//  WAIT    | waiting for the beat data
//  WRITE   | writing buffered words one per cycle
//  TAG     | tag and status array update
//  RESTART | replay missed address into stage 1
module icache_refill_controller
  import icache_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_halt,
  input  logic         i_miss_valid,
  input  logic [7:0]   i_miss_tag,
  input  logic [3:0]   i_miss_set,
  input  logic [3:0]   i_miss_offset,
  input  logic [7:0]   i_miss_status,
  output logic         o_miss_ready,
  output logic [15:0]  o_mem_addr,
  output logic         o_mem_req_valid,
  input  logic         i_mem_req_ready,
  input  logic [127:0] i_mem_data,
  input  logic         i_mem_data_valid,
  output logic [7:0]   o_da_w_addr,
  output logic [19:0]  o_da_w_data,
  output logic [3:0]   o_da_w_mask,
  output logic         o_da_w_valid,
  output logic [3:0]   o_ta_w_addr,
  output logic [31:0]  o_ta_w_data,
  output logic [3:0]   o_ta_w_mask,
  output logic         o_ta_w_valid,
  output logic [3:0]   o_sa_w_addr,
  output logic [7:0]   o_sa_w_data,
  output logic [7:0]   o_sa_w_mask,
  output logic         o_sa_w_valid,
  output logic [15:0]  o_restart_addr,
  output logic         o_restart_valid,
  input  logic         i_restart_ready,
  output logic         o_halt_pipe
);

  logic [2:0]                     state;
  logic [1:0]                     beat;
  logic [1:0]                     word;
  logic [TAG_BITS_WIDTH-1:0]      lat_tag;
  logic [SET_BITS_WIDTH-1:0]      lat_set;
  logic [BLOCK_OFFSET_BITS_WIDTH-1:0] lat_off;
  logic [NUM_WAYS-1:0]            lat_victim;
  logic [STATUS_WIDTH-1:0]        lat_status;
  logic [STATUS_WIDTH-1:0]        lat_mask;
  logic [BEAT_BITS-1:0]           beat_buf;
  logic [NUM_WAYS-1:0]            sel_victim;
  logic [STATUS_WIDTH-1:0]        sel_status;
  logic [STATUS_WIDTH-1:0]        sel_mask;
  logic [WORD_WIDTH-1:0]          cur_word;
  logic                           mem_hi_unused;

  assign mem_hi_unused = ^i_mem_data[MEM_IF_DATA_WIDTH-1:BEAT_BITS];

  icache_victim_select u_victim (
    .status      (i_miss_status),
    .victim      (sel_victim),
    .new_status  (sel_status),
    .status_mask (sel_mask)
  );

  // Refill sequencing; i_halt only freezes the array-facing states.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      beat       <= '0;
      word       <= '0;
      lat_tag    <= '0;
      lat_set    <= '0;
      lat_off    <= '0;
      lat_victim <= '0;
      lat_status <= '0;
      lat_mask   <= '0;
      beat_buf   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (i_miss_valid) begin
          lat_tag    <= i_miss_tag;
          lat_set    <= i_miss_set;
          lat_off    <= i_miss_offset;
          lat_victim <= sel_victim;
          lat_status <= sel_status;
          lat_mask   <= sel_mask;
          beat       <= '0;
          state      <= ST_REQ;
        end
        ST_REQ: if (i_mem_req_ready) state <= ST_WAIT;
        ST_WAIT: if (i_mem_data_valid) begin
          beat_buf <= i_mem_data[BEAT_BITS-1:0];
          word     <= '0;
          state    <= ST_WRITE;
        end
        ST_WRITE: if (!i_halt) begin
          word <= word + 2'd1;
          if (word == 2'd3) begin
            if (beat == 2'd3) begin
              state <= ST_TAG;
            end else begin
              beat  <= beat + 2'd1;
              state <= ST_REQ;
            end
          end
        end
        ST_TAG: if (!i_halt) state <= ST_RESTART;
        ST_RESTART: if (!i_halt && i_restart_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Word select out of the buffered beat.
  always_comb begin
    case (word)
      2'd0:    cur_word = beat_buf[0*WORD_WIDTH +: WORD_WIDTH];
      2'd1:    cur_word = beat_buf[1*WORD_WIDTH +: WORD_WIDTH];
      2'd2:    cur_word = beat_buf[2*WORD_WIDTH +: WORD_WIDTH];
      default: cur_word = beat_buf[3*WORD_WIDTH +: WORD_WIDTH];
    endcase
  end

  assign o_miss_ready    = (state == ST_IDLE);
  assign o_halt_pipe     = (state != ST_IDLE);
  assign o_mem_req_valid = (state == ST_REQ);
  assign o_mem_addr      = {lat_tag, lat_set, beat, 2'b00};

  assign o_da_w_valid    = (state == ST_WRITE) && !i_halt;
  assign o_da_w_addr     = {lat_set, beat, word};
  assign o_da_w_data     = cur_word;
  assign o_da_w_mask     = lat_victim;

  assign o_ta_w_valid    = (state == ST_TAG) && !i_halt;
  assign o_ta_w_addr     = lat_set;
  assign o_ta_w_data     = {NUM_WAYS{lat_tag}};
  assign o_ta_w_mask     = lat_victim;

  assign o_sa_w_valid    = (state == ST_TAG) && !i_halt;
  assign o_sa_w_addr     = lat_set;
  assign o_sa_w_data     = lat_status;
  assign o_sa_w_mask     = lat_mask;

  assign o_restart_valid = (state == ST_RESTART) && !i_halt;
  assign o_restart_addr  = {lat_tag, lat_set, lat_off};

endmodule

// File: tb/tb_icache_refill_controller.sv
// Directed bench for the icache refill controller with a zero/fixed-wait
// memory model that returns address-derived words.
module tb_icache_refill_controller;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_halt;
  logic         i_miss_valid;
  logic [7:0]   i_miss_tag;
  logic [3:0]   i_miss_set;
  logic [3:0]   i_miss_offset;
  logic [7:0]   i_miss_status;
  logic         o_miss_ready;
  logic [15:0]  o_mem_addr;
  logic         o_mem_req_valid;
  logic         i_mem_req_ready;
  logic [127:0] i_mem_data;
  logic         i_mem_data_valid;
  logic [7:0]   o_da_w_addr;
  logic [19:0]  o_da_w_data;
  logic [3:0]   o_da_w_mask;
  logic         o_da_w_valid;
  logic [3:0]   o_ta_w_addr;
  logic [31:0]  o_ta_w_data;
  logic [3:0]   o_ta_w_mask;
  logic         o_ta_w_valid;
  logic [3:0]   o_sa_w_addr;
  logic [7:0]   o_sa_w_data;
  logic [7:0]   o_sa_w_mask;
  logic         o_sa_w_valid;
  logic [15:0]  o_restart_addr;
  logic         o_restart_valid;
  logic         i_restart_ready;
  logic         o_halt_pipe;

  icache_refill_controller dut (
    .clk(clk), .rst(rst), .i_halt(i_halt),
    .i_miss_valid(i_miss_valid), .i_miss_tag(i_miss_tag), .i_miss_set(i_miss_set),
    .i_miss_offset(i_miss_offset), .i_miss_status(i_miss_status),
    .o_miss_ready(o_miss_ready), .o_mem_addr(o_mem_addr), .o_mem_req_valid(o_mem_req_valid),
    .i_mem_req_ready(i_mem_req_ready), .i_mem_data(i_mem_data), .i_mem_data_valid(i_mem_data_valid),
    .o_da_w_addr(o_da_w_addr), .o_da_w_data(o_da_w_data), .o_da_w_mask(o_da_w_mask),
    .o_da_w_valid(o_da_w_valid), .o_ta_w_addr(o_ta_w_addr), .o_ta_w_data(o_ta_w_data),
    .o_ta_w_mask(o_ta_w_mask), .o_ta_w_valid(o_ta_w_valid), .o_sa_w_addr(o_sa_w_addr),
    .o_sa_w_data(o_sa_w_data), .o_sa_w_mask(o_sa_w_mask), .o_sa_w_valid(o_sa_w_valid),
    .o_restart_addr(o_restart_addr), .o_restart_valid(o_restart_valid),
    .i_restart_ready(i_restart_ready), .o_halt_pipe(o_halt_pipe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] tag;
    logic [3:0] set;
    logic [3:0] off;
    logic [7:0] status;
    logic [3:0] way;
    logic [7:0] sa_data;
    logic [7:0] sa_mask;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int cyc;
  int req_delay_left;
  logic        mem_pend;
  logic [15:0] mem_pend_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [19:0] mem_word(input logic [15:0] a);
    return {4'h5, a ^ 16'h9C3E};
  endfunction

  function automatic logic [127:0] mem_beat(input logic [15:0] a);
    logic [127:0] d;
    logic [1:0] k2;
    d = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < 4; k++) begin
      k2 = k[1:0];
      d[20*k +: 20] = mem_word({a[15:2], k2});
    end
    return d;
  endfunction

  // Memory model + one clock; outputs are looked at 1 time unit after posedge.
  task automatic step();
    i_mem_data_valid = mem_pend;
    if (mem_pend) i_mem_data = mem_beat(mem_pend_addr);
    else i_mem_data = {$urandom, $urandom, $urandom, $urandom};
    if (o_mem_req_valid && req_delay_left > 0) begin
      i_mem_req_ready = 1'b0;
      req_delay_left--;
    end else begin
      i_mem_req_ready = 1'b1;
    end
    mem_pend = o_mem_req_valid && i_mem_req_ready;
    mem_pend_addr = o_mem_addr;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_miss(input vec_t v, input int req_delay, input int halt_at,
                          input bit hold_next, input vec_t nxt, input int exp_lat);
    int nreq = 0, nw = 0, nta = 0, nsa = 0, halt_left = 0;
    bit done = 0, req_open = 0, halted = 0;
    logic [15:0] req_addr = '0;
    logic [1:0]  b2, w2;
    logic [15:0] exp_a;
    i_miss_tag = v.tag; i_miss_set = v.set; i_miss_offset = v.off;
    i_miss_status = v.status; i_miss_valid = 1'b1;
    req_delay_left = req_delay;
    cyc = 0;
    step();
    if (hold_next) begin
      i_miss_tag = nxt.tag; i_miss_set = nxt.set; i_miss_offset = nxt.off;
      i_miss_status = nxt.status;
    end else begin
      i_miss_valid = 1'b0;
    end
    while (!done && cyc < 80) begin
      if (o_halt_pipe !== 1'b1 || o_miss_ready !== 1'b0)
        chk("busy_flags", {o_halt_pipe, o_miss_ready}, 2'b10);
      if (halt_left > 0) begin
        chk("halt_no_strobe", {o_da_w_valid, o_ta_w_valid, o_sa_w_valid, o_restart_valid}, 4'b0);
        halt_left--;
        if (halt_left == 0) i_halt = 1'b0;
      end
      if (o_mem_req_valid) begin
        if (!req_open) begin
          b2 = nreq[1:0];
          chk("mem_addr", o_mem_addr, {v.tag, v.set, b2, 2'b00});
          req_addr = o_mem_addr;
          req_open = 1;
          nreq++;
        end else begin
          chk("mem_addr_stable", o_mem_addr, req_addr);
        end
      end
      if (req_open && req_delay_left == 0) req_open = 0;
      if (o_da_w_valid) begin
        b2 = nw[3:2]; w2 = nw[1:0];
        exp_a = {v.tag, v.set, b2, w2};
        chk("da_addr", o_da_w_addr, {v.set, b2, w2});
        chk("da_data", o_da_w_data, mem_word(exp_a));
        chk("da_mask", o_da_w_mask, v.way);
        nw++;
        if (nw == halt_at && !halted) begin
          halted = 1; halt_left = 3; i_halt = 1'b1;
        end
      end
      if (o_ta_w_valid) begin
        chk("ta_addr", o_ta_w_addr, v.set);
        chk("ta_data", o_ta_w_data, {4{v.tag}});
        chk("ta_mask", o_ta_w_mask, v.way);
        chk("tag_before_restart", nw, 16);
        nta++;
      end
      if (o_sa_w_valid) begin
        chk("sa_addr", o_sa_w_addr, v.set);
        chk("sa_data", o_sa_w_data, v.sa_data);
        chk("sa_mask", o_sa_w_mask, v.sa_mask);
        nsa++;
      end
      if (o_restart_valid) begin
        chk("restart_addr", o_restart_addr, {v.tag, v.set, v.off});
        chk("restart_latency", cyc, exp_lat);
        done = 1;
      end
      step();
    end
    chk("restart_seen", done, 1);
    chk("req_count", nreq, 4);
    chk("write_count", nw, 16);
    chk("tag_count", nta, 1);
    chk("status_count", nsa, 1);
  endtask

  vec_t vecs[4];
  vec_t none;

  initial begin
    vecs[0] = '{tag:8'h3A, set:4'h5, off:4'h7, status:8'h00, way:4'b0001, sa_data:8'h03, sa_mask:8'h03};
    vecs[1] = '{tag:8'hC4, set:4'h9, off:4'h0, status:8'hBF, way:4'b1000, sa_data:8'hEA, sa_mask:8'hFF};
    vecs[2] = '{tag:8'h12, set:4'hF, off:4'hF, status:8'hFF, way:4'b0001, sa_data:8'hAB, sa_mask:8'hFF};
    vecs[3] = '{tag:8'h7E, set:4'h0, off:4'h3, status:8'h8F, way:4'b0100, sa_data:8'hBF, sa_mask:8'h30};
    vecs[0].status = 8'h00;
    none = vecs[0];

    rst = 1'b1; i_halt = 1'b0; i_miss_valid = 1'b0; i_miss_tag = '0; i_miss_set = '0;
    i_miss_offset = '0; i_miss_status = '0; i_mem_req_ready = 1'b1; i_mem_data = '0;
    i_mem_data_valid = 1'b0; i_restart_ready = 1'b1; mem_pend = 1'b0; mem_pend_addr = '0;
    req_delay_left = 0; cyc = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_ready", o_miss_ready, 1);
    chk("reset_valids", {o_halt_pipe, o_mem_req_valid, o_da_w_valid, o_ta_w_valid,
                         o_sa_w_valid, o_restart_valid}, 6'b0);

    // Table of full misses with zero-wait memory.
    for (int i = 0; i < 4; i++) begin
      run_miss(vecs[i], 0, -1, 0, none, 26);
      chk("idle_after", {o_miss_ready, o_halt_pipe}, 2'b10);
    end

    // Halt for 3 cycles in the middle of beat 1's writes.
    run_miss(vecs[1], 0, 6, 0, none, 29);

    // Stray beat in IDLE, slow request accept, second miss held while busy.
    mem_pend = 1'b1; mem_pend_addr = 16'hFFFC;
    step();
    chk("stray_no_req", {o_mem_req_valid, o_miss_ready}, 2'b01);
    step();
    run_miss(vecs[0], 5, -1, 1, vecs[3], 31);
    chk("second_miss_waits_idle", {o_miss_ready, o_halt_pipe}, 2'b10);
    run_miss(vecs[3], 0, -1, 0, none, 26);

    // Reset in the middle of beat 2's writes.
    i_miss_tag = 8'h3A; i_miss_set = 4'h5; i_miss_offset = 4'h7; i_miss_status = 8'h00;
    i_miss_valid = 1'b1;
    cyc = 0;
    step();
    i_miss_valid = 1'b0;
    while (cyc < 16) step();
    chk("pre_rst_write", {o_da_w_valid, o_da_w_addr}, {1'b1, 8'h59});
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_idle", {o_miss_ready, o_halt_pipe, o_mem_req_valid, o_da_w_valid,
                     o_ta_w_valid, o_sa_w_valid, o_restart_valid}, 7'b1000000);
    begin
      int strobes = 0;
      for (int i = 0; i < 30; i++) begin
        step();
        if (o_mem_req_valid || o_da_w_valid || o_ta_w_valid || o_sa_w_valid || o_restart_valid)
          strobes++;
      end
      chk("rst_no_writes", strobes, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
